// File: rtl/huffman_canon_decoder.sv
// Bit-serial canonical Huffman decoder: one code bit per accepted cycle, one symbol per codeword.
// Per-length code counts and the canonical symbol table are writable through a small config port.
module huffman_canon_decoder #(
    parameter int SYM_W   = 3,
    parameter int MAX_LEN = 4,
    parameter int NSYM    = 8,
    localparam int CNT_W  = $clog2(NSYM + 1),
    localparam int IDX_W  = $clog2(NSYM),
    localparam int LA_W   = $clog2(MAX_LEN),
    localparam int ADDR_W = (IDX_W > LA_W) ? ((IDX_W > 0) ? IDX_W : 1) : ((LA_W > 0) ? LA_W : 1),
    localparam int CDAT_W = (SYM_W > CNT_W) ? SYM_W : CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SYM_W-1:0]  out_sym,
    output logic              out_err,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CDAT_W-1:0] cfg_data
);

    // Headroom above MAX_LEN+1 so an over-full count table cannot wrap first/index.
    localparam int AW    = MAX_LEN + CNT_W + 2;
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    function automatic logic [CNT_W-1:0] cnt_default(input int code_len);
        case (code_len)
            1:       return CNT_W'(1);
            3:       return CNT_W'(3);
            4:       return CNT_W'(2);
            default: return '0;
        endcase
    endfunction

    function automatic logic [SYM_W-1:0] sym_default(input int idx);
        return (idx < 6) ? SYM_W'(idx + 1) : '0;
    endfunction

    logic signed [AW-1:0] code_q, code_d, first_q, first_d, index_q, index_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [CNT_W-1:0]     cnt_q [MAX_LEN];
    logic [CNT_W-1:0]     cnt_d [MAX_LEN];
    logic [SYM_W-1:0]     sym_tab_q [NSYM];
    logic [SYM_W-1:0]     sym_tab_d [NSYM];
    logic                 out_valid_q, out_valid_d, out_err_q, out_err_d;
    logic [SYM_W-1:0]     out_sym_q, out_sym_d;

    logic                 accept, hit, at_max, in_range, final_bit;
    logic [CNT_W-1:0]     cur_cnt;
    logic [SYM_W-1:0]     tab_sym;
    logic signed [AW-1:0] c, f, diff, cnt_s, sym_idx;

    assign in_ready  = (!out_valid_q || out_ready) && !cfg_we;
    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_err   = out_err_q;

    always_comb begin
        accept  = in_valid && in_ready;
        cur_cnt = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (len_q == LEN_W'(i)) cur_cnt = cnt_q[i];
        end
        c       = (code_q <<< 1) | $signed({{(AW-1){1'b0}}, in_bit});
        f       = first_q <<< 1;
        diff    = c - f;
        cnt_s   = $signed({{(AW-CNT_W){1'b0}}, cur_cnt});
        sym_idx = index_q + diff;
        hit     = !diff[AW-1] && (diff < cnt_s);
        at_max  = (len_q == LEN_W'(MAX_LEN - 1));

        tab_sym  = '0;
        in_range = 1'b0;
        for (int i = 0; i < NSYM; i++) begin
            if (sym_idx == AW'(i)) begin
                tab_sym  = sym_tab_q[i];
                in_range = 1'b1;
            end
        end
        final_bit = hit || at_max;

        code_d  = code_q;
        first_d = first_q;
        index_d = index_q;
        len_d   = len_q;
        if (cfg_we || (accept && final_bit)) begin
            code_d  = '0;
            first_d = '0;
            index_d = '0;
            len_d   = '0;
        end else if (accept) begin
            code_d  = c;
            first_d = f + cnt_s;
            index_d = index_q + cnt_s;
            len_d   = len_q + LEN_W'(1);
        end

        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_err_d   = out_err_q;
        if (accept && final_bit) begin
            out_valid_d = 1'b1;
            out_err_d   = !(hit && in_range);
            out_sym_d   = (hit && in_range) ? tab_sym : '0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        for (int i = 0; i < MAX_LEN; i++) cnt_d[i] = cnt_q[i];
        for (int i = 0; i < NSYM; i++) sym_tab_d[i] = sym_tab_q[i];
        // Addresses beyond the selected table match no entry and are dropped.
        if (cfg_we) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (!cfg_sel && cfg_addr == ADDR_W'(i)) cnt_d[i] = cfg_data[CNT_W-1:0];
            end
            for (int i = 0; i < NSYM; i++) begin
                if (cfg_sel && cfg_addr == ADDR_W'(i)) sym_tab_d[i] = cfg_data[SYM_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q      <= '0;
            first_q     <= '0;
            index_q     <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_sym_q   <= '0;
            out_err_q   <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) cnt_q[i] <= cnt_default(i + 1);
            for (int i = 0; i < NSYM; i++) sym_tab_q[i] <= sym_default(i);
        end else begin
            code_q      <= code_d;
            first_q     <= first_d;
            index_q     <= index_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_err_q   <= out_err_d;
            for (int i = 0; i < MAX_LEN; i++) cnt_q[i] <= cnt_d[i];
            for (int i = 0; i < NSYM; i++) sym_tab_q[i] <= sym_tab_d[i];
        end
    end

endmodule

// File: tb/tb_huffman_canon_decoder.sv
// Scoreboard bench for huffman_canon_decoder: expected symbols queued as codewords are driven,
// popped by a monitor on every output handshake.
module tb_huffman_canon_decoder;

    localparam int SYM_W   = 3;
    localparam int MAX_LEN = 4;
    localparam int NSYM    = 8;
    localparam int ADDR_W  = 3;
    localparam int CDAT_W  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_bit = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [SYM_W-1:0]  out_sym;
    logic              out_err;
    logic              cfg_we = 1'b0;
    logic              cfg_sel = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [CDAT_W-1:0] cfg_data = '0;

    int checks = 0;
    int failures = 0;
    logic [SYM_W:0] exp_q[$];

    huffman_canon_decoder #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .NSYM(NSYM)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_err(out_err),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    // A handshake completes on the next rising edge whenever valid&&ready hold at the falling edge.
    always @(negedge clk) begin
        logic [SYM_W:0] e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output got sym=%0d err=%0d, required no output", out_sym, out_err);
            end else begin
                e = exp_q.pop_front();
                if ({out_err, out_sym} !== e) begin
                    failures++;
                    $display("FAIL scoreboard got sym=%0d err=%0d, required sym=%0d err=%0d",
                             out_sym, out_err, e[SYM_W-1:0], e[SYM_W]);
                end
            end
        end
    end

    task automatic expect_sym(input logic [SYM_W-1:0] s, input logic e);
        exp_q.push_back({e, s});
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that accepted the bit.
    task automatic send_bit(input logic b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_bit_timeout got in_ready=0 for 20 cycles, required 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic sel, input logic [ADDR_W-1:0] addr, input logic [CDAT_W-1:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL cfg_blocks_in_ready got %b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({out_valid, out_sym, out_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b sym=%0d err=%b, required 0 0 0", out_valid, out_sym, out_err);
        end
        #10 reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        expect_sym(3'd1, 1'b0);
        send_bit(1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 3'd1) begin
            failures++;
            $display("FAIL basic_a got valid=%b sym=%0d, required 1 1", out_valid, out_sym);
        end
        send_bit(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_no_out_bit2 got valid=%b, required 0", out_valid);
        end
        send_bit(1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_no_out_bit3 got valid=%b, required 0", out_valid);
        end
        expect_sym(3'd3, 1'b0);
        send_bit(1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 3'd3) begin
            failures++;
            $display("FAIL basic_c got valid=%b sym=%0d, required 1 3", out_valid, out_sym);
        end
    endtask

    task automatic test_long_codes;
        expect_sym(3'd6, 1'b0);
        repeat (4) send_bit(1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 3'd6 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL long_f got valid=%b sym=%0d err=%b, required 1 6 0", out_valid, out_sym, out_err);
        end
        expect_sym(3'd4, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 3'd4 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL long_d got valid=%b sym=%0d err=%b, required 1 4 0", out_valid, out_sym, out_err);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        expect_sym(3'd1, 1'b0);
        send_bit(1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 3'd1) begin
            failures++;
            $display("FAIL stall_first got valid=%b sym=%0d, required 1 1", out_valid, out_sym);
        end
        in_valid = 1'b1;
        in_bit   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sym !== 3'd1) begin
                failures++;
                $display("FAIL stall_hold cycle %0d got ready=%b valid=%b sym=%0d, required 0 1 1",
                         k, in_ready, out_valid, out_sym);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        expect_sym(3'd1, 1'b0);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_ready got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 3'd1) begin
            failures++;
            $display("FAIL stall_reload got valid=%b sym=%0d, required 1 1", out_valid, out_sym);
        end
    endtask

    task automatic test_cfg_error;
        cfg_write(1'b0, 3'd3, 4'd1);
        expect_sym(3'd0, 1'b1);
        repeat (4) send_bit(1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_sym !== 3'd0) begin
            failures++;
            $display("FAIL cfg_err got valid=%b err=%b sym=%0d, required 1 1 0", out_valid, out_err, out_sym);
        end
        expect_sym(3'd1, 1'b0);
        send_bit(1'b0);
        cfg_write(1'b0, 3'd3, 4'd2);
        cfg_write(1'b0, 3'd5, 4'd15);
        expect_sym(3'd6, 1'b0);
        repeat (4) send_bit(1'b1);
        checks++;
        if (out_sym !== 3'd6 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL cfg_out_of_range got sym=%0d err=%b, required 6 0", out_sym, out_err);
        end
    endtask

    task automatic test_async_reset;
        send_bit(1'b1);
        send_bit(1'b1);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sym !== 3'd0 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got valid=%b sym=%0d err=%b, required 0 0 0", out_valid, out_sym, out_err);
        end
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        expect_sym(3'd1, 1'b0);
        send_bit(1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 3'd1 || out_err !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_decode got valid=%b sym=%0d err=%b, required 1 1 0", out_valid, out_sym, out_err);
        end
    endtask

    task automatic test_cfg_abort;
        send_bit(1'b1);
        cfg_write(1'b1, 3'd0, 4'd7);
        expect_sym(3'd7, 1'b0);
        send_bit(1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sym !== 3'd7) begin
            failures++;
            $display("FAIL cfg_abort got valid=%b sym=%0d, required 1 7", out_valid, out_sym);
        end
        cfg_write(1'b1, 3'd0, 4'd1);
    endtask

    task automatic test_back_to_back;
        logic [3:0] codes [6];
        int         lens  [6];
        logic [3:0] cv;
        int         k;
        codes = '{4'd0, 4'd4, 4'd5, 4'd6, 4'd14, 4'd15};
        lens  = '{1, 3, 3, 3, 4, 4};
        out_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            k  = $urandom_range(0, 5);
            cv = codes[k];
            expect_sym(SYM_W'(k + 1), 1'b0);
            for (int j = lens[k] - 1; j >= 0; j--) send_bit(cv[j]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_long_codes();
        test_stall();
        test_cfg_error();
        test_async_reset();
        test_back_to_back();
        test_cfg_abort();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
